// File: rtl/spi_slave_shift.sv
// SPI mode-0 target: oversamples SCK/CS_N/MOSI into clk and shifts WIDTH-bit
// words MSB first, with a one-entry TX holding register and an RX output register.
module spi_slave_shift #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sck,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_hist_q, cs_hist_q;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]       hold_q, hold_d;
  logic                   tx_pending_q, tx_pending_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_overrun_q, rx_overrun_d;

  logic             sck_s, cs_n_s, mosi_s, sel;
  logic             sck_rise, sck_fall, cs_fall, cs_rise;
  logic             load, complete;
  logic [WIDTH-1:0] rx_word;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign sel    = !cs_n_s;

  // SCK edges only count while the synchronised select is active.
  assign sck_rise = sel && sck_s && !sck_hist_q;
  assign sck_fall = sel && !sck_s && sck_hist_q;
  assign cs_fall  = cs_hist_q && !cs_n_s;
  assign cs_rise  = !cs_hist_q && cs_n_s;

  assign load     = cs_fall || (sck_fall && bit_cnt_q == '0);
  assign complete = sck_rise && bit_cnt_q == LAST_BIT;
  assign rx_word  = {rx_shift_q[WIDTH-2:0], mosi_s};

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    hold_d       = hold_q;
    tx_pending_d = tx_pending_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = 1'b0;

    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (tx_valid && !tx_pending_q) begin
      hold_d       = tx_data;
      tx_pending_d = 1'b1;
    end

    // A load with nothing pending returns zeros (underrun).
    if (load) begin
      if (tx_pending_q) begin
        tx_shift_d   = hold_q;
        tx_pending_d = 1'b0;
      end else begin
        tx_shift_d   = '0;
      end
    end else if (sck_fall) begin
      tx_shift_d = tx_shift_q << 1;
    end

    if (sck_rise) begin
      rx_shift_d = rx_word;
      bit_cnt_d  = complete ? '0 : bit_cnt_q + 1'b1;
    end

    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (cs_rise) begin
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sck_sync_q   <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sck_hist_q   <= 1'b0;
      cs_hist_q    <= 1'b1;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      tx_pending_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_hist_q   <= sck_s;
      cs_hist_q    <= cs_n_s;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      tx_pending_q <= tx_pending_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  // NOTE: the holding register is only read while tx_pending_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign busy        = (state_q == SHIFT);
  assign spi_miso_oe = busy;
  assign spi_miso    = busy ? tx_shift_q[WIDTH-1] : 1'b0;
  assign tx_ready    = !tx_pending_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;

endmodule
